// File: rtl/ttl_gen_axi_txn_arb.sv
// Round-robin arbiter and sequencer that shares one AXI-lite transaction
// engine among NUM_REQ requesters: it grants one request, fires the engine
// init pulse, waits for done/error (or a watchdog timeout) and returns a
// one-cycle response to the winner.
module ttl_gen_axi_txn_arb #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic                          rsp_error,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          eng_init_txn,
  output logic                          eng_write,
  output logic [ADDR_WIDTH-1:0]         eng_addr,
  output logic [DATA_WIDTH-1:0]         eng_wdata,
  input  logic                          eng_txn_done,
  input  logic                          eng_error,
  input  logic [DATA_WIDTH-1:0]         eng_rdata,
  output logic                          busy,
  output logic                          timeout_flag
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = IDX_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       last_grant_q, last_grant_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   eng_write_q, eng_write_d;
  logic [ADDR_WIDTH-1:0]  eng_addr_q, eng_addr_d;
  logic [DATA_WIDTH-1:0]  eng_wdata_q, eng_wdata_d;
  logic                   rsp_error_q, rsp_error_d;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                   timeout_flag_q, timeout_flag_d;

  logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];
  logic                   arb_found;
  logic [IDX_W-1:0]       arb_idx;
  logic [SUM_W-1:0]       arb_sum;
  logic [IDX_W-1:0]       arb_cand;
  logic [NUM_REQ-1:0]     grant_oh;

  // Unflatten the per-requester payload buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Round-robin search: first asserted request after last_grant, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    arb_found = 1'b0;
    arb_idx   = last_grant_q;
    arb_sum   = '0;
    arb_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      arb_sum = {1'b0, last_grant_q} + SUM_W'(k);
      if (arb_sum >= SUM_W'(NUM_REQ)) begin
        arb_sum = arb_sum - SUM_W'(NUM_REQ);
      end
      arb_cand = arb_sum[IDX_W-1:0];
      if (!arb_found && req_valid[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
  end

  // Next-state logic: arbitrate, issue, wait with watchdog, respond.
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    cnt_d          = cnt_q;
    eng_write_d    = eng_write_q;
    eng_addr_d     = eng_addr_q;
    eng_wdata_d    = eng_wdata_q;
    rsp_error_d    = rsp_error_q;
    rsp_rdata_d    = rsp_rdata_q;
    timeout_flag_d = timeout_flag_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          state_d     = ST_ISSUE;
          grant_d     = arb_idx;
          eng_write_d = req_write[arb_idx];
          eng_addr_d  = addr_arr[arb_idx];
          eng_wdata_d = wdata_arr[arb_idx];
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        // Done takes priority over a watchdog expiry in the same cycle.
        if (eng_txn_done) begin
          state_d     = ST_RESP;
          rsp_error_d = eng_error;
          rsp_rdata_d = eng_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d        = ST_RESP;
          rsp_error_d    = 1'b1;
          rsp_rdata_d    = '0;
          timeout_flag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d      = ST_IDLE;
        last_grant_d = grant_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q        <= ST_IDLE;
      grant_q        <= '0;
      last_grant_q   <= IDX_W'(NUM_REQ - 1);
      cnt_q          <= '0;
      eng_write_q    <= 1'b0;
      eng_addr_q     <= '0;
      eng_wdata_q    <= '0;
      rsp_error_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
      eng_write_q    <= eng_write_d;
      eng_addr_q     <= eng_addr_d;
      eng_wdata_q    <= eng_wdata_d;
      rsp_error_q    <= rsp_error_d;
      rsp_rdata_q    <= rsp_rdata_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign grant_oh     = NUM_REQ'(1) << grant_q;
  assign req_ready    = (state_q == ST_ISSUE) ? grant_oh : '0;
  assign rsp_valid    = (state_q == ST_RESP)  ? grant_oh : '0;
  assign rsp_error    = (state_q == ST_RESP) && rsp_error_q;
  assign rsp_rdata    = (state_q == ST_RESP)  ? rsp_rdata_q : '0;
  assign eng_init_txn = (state_q == ST_ISSUE);
  assign eng_write    = eng_write_q;
  assign eng_addr     = eng_addr_q;
  assign eng_wdata    = eng_wdata_q;
  assign busy         = (state_q != ST_IDLE);
  assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_ttl_gen_axi_txn_arb.sv
// Self-checking bench for ttl_gen_axi_txn_arb: reactive requester and engine
// agents, a timestamp-based transaction model compared every cycle, and
// directed scenarios pinned with literal expectations.
module tb_ttl_gen_axi_txn_arb;

  localparam int NR  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic              ACLK = 1'b0;
  logic              ARESET = 1'b1;
  logic [NR-1:0]     req_valid = '0, req_write = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     req_ready, rsp_valid;
  logic              rsp_error;
  logic [DW-1:0]     rsp_rdata;
  logic              eng_init_txn, eng_write;
  logic [AW-1:0]     eng_addr;
  logic [DW-1:0]     eng_wdata;
  logic              eng_txn_done = 1'b0, eng_error = 1'b0;
  logic [DW-1:0]     eng_rdata = '0;
  logic              busy, timeout_flag;

  ttl_gen_axi_txn_arb #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_rdata(rsp_rdata),
    .eng_init_txn(eng_init_txn), .eng_write(eng_write), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
    .eng_txn_done(eng_txn_done), .eng_error(eng_error), .eng_rdata(eng_rdata),
    .busy(busy), .timeout_flag(timeout_flag)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- transaction model (timestamps per transaction) --------
  bit          m_active;
  int          m_g, m_last, m_t_issue, m_t_resp, m_wait_start;
  bit          m_write, m_err, m_tflag;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  task automatic model_reset();
    m_active = 0; m_g = 0; m_last = NR - 1; m_t_issue = -1; m_t_resp = -1;
    m_wait_start = -1; m_err = 0; m_rdata = '0; m_tflag = 0;
  endtask

  // Advance the model across the clock edge that ends cycle c.
  task automatic model_step(input int c);
    int idx;
    bit found;
    if (ARESET) begin
      model_reset();
      return;
    end
    if (!m_active) begin
      found = 0;
      for (int k = 1; k <= NR; k++) begin
        idx = (m_last + k) % NR;
        if (!found && req_valid[idx]) begin
          found = 1; m_g = idx;
        end
      end
      if (found) begin
        m_active = 1; m_t_issue = c + 1; m_wait_start = c + 2; m_t_resp = -1;
        m_write = req_write[m_g];
        m_addr  = req_addr[m_g*AW +: AW];
        m_wdata = req_wdata[m_g*DW +: DW];
      end
    end else if (m_t_resp == c) begin
      m_last = m_g; m_active = 0;
    end else if (m_t_resp < 0 && c >= m_wait_start) begin
      if (eng_txn_done) begin
        m_t_resp = c + 1; m_err = eng_error; m_rdata = eng_rdata;
      end else if (c - m_wait_start == TMO - 1) begin
        m_t_resp = c + 1; m_err = 1; m_rdata = '0; m_tflag = 1;
      end
    end
  endtask

  task automatic compare(input int c);
    bit in_issue, in_resp;
    logic [NR-1:0] oh;
    in_issue = m_active && (c == m_t_issue);
    in_resp  = m_active && (c == m_t_resp);
    oh = NR'(1) << m_g;
    check("busy", busy, m_active);
    check("eng_init_txn", eng_init_txn, in_issue);
    check("req_ready", req_ready, in_issue ? oh : '0);
    check("rsp_valid", rsp_valid, in_resp ? oh : '0);
    check("rsp_error", rsp_error, in_resp ? m_err : 1'b0);
    check("rsp_rdata", rsp_rdata, in_resp ? m_rdata : '0);
    check("timeout_flag", timeout_flag, m_tflag);
    if (m_active) begin
      check("eng_write", eng_write, m_write);
      check("eng_addr", eng_addr, m_addr);
      check("eng_wdata", eng_wdata, m_wdata);
    end
  endtask

  // ---------------- observation log for directed checks -------------------
  int grants[$];
  int init_cycs[$];
  int rsp_cycs[$];
  int n_inits = 0, rsp_count = 0, last_rsp_idx = -1;
  logic last_rsp_err, init_write;
  logic [DW-1:0] last_rsp_rdata, init_wdata;
  logic [AW-1:0] init_addr;

  task automatic log_outputs(input int c);
    if (eng_init_txn) begin
      n_inits++; init_cycs.push_back(c);
      init_addr = eng_addr; init_write = eng_write; init_wdata = eng_wdata;
    end
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i]) grants.push_back(i);
      if (rsp_valid[i]) begin
        rsp_count++; rsp_cycs.push_back(c); last_rsp_idx = i;
        last_rsp_err = rsp_error; last_rsp_rdata = rsp_rdata;
      end
    end
  endtask

  // ---------------- requester and engine agents ---------------------------
  bit en[NR], pend[NR], wrsp[NR];
  int gap[NR], assert_cyc[NR];
  bit pay_write[NR];
  logic [AW-1:0] pay_addr[NR];
  logic [DW-1:0] pay_wdata[NR];
  bit one_shot = 1, rand_pay = 0, rand_gap = 0, rand_stray = 0;
  int gap_max = 4;

  bit eng_never = 0, eng_fix_res = 0, eng_outst = 0, fix_err = 0;
  int eng_fix_delay = 0, done_at = -1, stray_at = -1;
  logic [DW-1:0] fix_rdata = '0;

  task automatic drive(input int c);
    bit dn;
    if (eng_init_txn) begin
      eng_outst = 1;
      done_at = eng_never ? -1 : c + ((eng_fix_delay > 0) ? eng_fix_delay : int'($urandom_range(1, 18)));
    end
    if (rsp_valid != '0) eng_outst = 0;
    dn = (c == done_at) || (c == stray_at) ||
         (rand_stray && !eng_outst && !eng_init_txn && $urandom_range(0, 49) == 0);
    eng_txn_done = dn;
    if (dn && c == done_at && eng_fix_res) begin
      eng_error = fix_err; eng_rdata = fix_rdata;
    end else begin
      eng_error = 1'($urandom); eng_rdata = $urandom;
    end
    for (int i = 0; i < NR; i++) begin
      if (pend[i] && req_ready[i]) begin
        pend[i] = 0; wrsp[i] = 1; req_valid[i] = 1'b0;
      end else if (wrsp[i] && rsp_valid[i]) begin
        wrsp[i] = 0; gap[i] = rand_gap ? int'($urandom_range(0, gap_max)) : 0;
      end else if (!pend[i] && !wrsp[i] && en[i]) begin
        if (gap[i] > 0) gap[i]--;
        else begin
          if (rand_pay) begin
            pay_write[i] = 1'($urandom); pay_addr[i] = $urandom; pay_wdata[i] = $urandom;
          end
          req_write[i] = pay_write[i];
          req_addr[i*AW +: AW]  = pay_addr[i];
          req_wdata[i*DW +: DW] = pay_wdata[i];
          req_valid[i] = 1'b1; pend[i] = 1; assert_cyc[i] = c;
          if (one_shot) en[i] = 0;
        end
      end else if (!pend[i] && rand_pay) begin
        // Idle requesters scramble their payload to catch wrong-slice capture.
        req_addr[i*AW +: AW] = $urandom; req_wdata[i*DW +: DW] = $urandom;
        req_write[i] = 1'($urandom);
      end
    end
  endtask

  task automatic tick();
    @(negedge ACLK);
    cyc++;
    model_step(cyc - 1);
    compare(cyc);
    log_outputs(cyc);
    drive(cyc);
  endtask

  task automatic clear_agents();
    for (int i = 0; i < NR; i++) begin
      en[i] = 0; pend[i] = 0; wrsp[i] = 0; gap[i] = 0;
    end
    req_valid = '0; eng_txn_done = 1'b0; eng_outst = 0; done_at = -1; stray_at = -1;
    eng_never = 0; eng_fix_res = 0; eng_fix_delay = 0; one_shot = 1;
    rand_pay = 0; rand_gap = 0; rand_stray = 0;
    grants.delete(); init_cycs.delete(); rsp_cycs.delete();
  endtask

  // Asynchronous reset mid-cycle, held for two clock cycles.
  task automatic do_reset();
    #2 ARESET = 1'b1;
    model_reset();
    clear_agents();
    #1;
    check("rst_ctl", {req_ready, rsp_valid, rsp_error, eng_init_txn, eng_write, busy, timeout_flag}, '0);
    check("rst_rdata", rsp_rdata, '0);
    check("rst_eng_addr", eng_addr, '0);
    check("rst_eng_wdata", eng_wdata, '0);
    tick();
    tick();
    ARESET = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget, input string name);
    int start, k;
    start = rsp_count; k = 0;
    while ((rsp_count - start) < n && k < budget) begin
      tick(); k++;
    end
    check(name, rsp_count - start, n);
  endtask

  int exp3[6] = '{0, 1, 2, 3, 0, 1};
  int base_inits, base_rsp;

  initial begin
    model_reset();
    clear_agents();
    tick();
    do_reset();

    // 1: single write from requester 0, engine done 3 cycles after init.
    pay_write[0] = 1; pay_addr[0] = 32'h40; pay_wdata[0] = 32'hA5A5_0001;
    eng_fix_delay = 3; eng_fix_res = 1; fix_err = 0; fix_rdata = 32'h1234;
    en[0] = 1;
    wait_rsp(1, 50, "t1_rsp_seen");
    check("t1_n_init", init_cycs.size(), 1);
    check("t1_ready_latency", init_cycs[0] - assert_cyc[0], 1);
    check("t1_grant", grants[0], 0);
    check("t1_eng_addr", init_addr, 32'h40);
    check("t1_eng_write", init_write, 1);
    check("t1_eng_wdata", init_wdata, 32'hA5A5_0001);
    check("t1_rsp_idx", last_rsp_idx, 0);
    check("t1_rsp_error", last_rsp_err, 0);
    check("t1_rsp_latency", rsp_cycs[0] - init_cycs[0], 4);

    // 2: requesters 1 and 2 rise together.
    do_reset();
    rand_pay = 1; en[1] = 1; en[2] = 1;
    wait_rsp(2, 100, "t2_rsp_seen");
    check("t2_n_grants", grants.size(), 2);
    check("t2_first", grants[0], 1);
    check("t2_second", grants[1], 2);
    check("t2_rearb_gap", init_cycs[1] - rsp_cycs[0], 2);

    // 3: all four requesters continuously re-requesting.
    do_reset();
    rand_pay = 1; one_shot = 0;
    base_inits = n_inits;
    for (int i = 0; i < NR; i++) en[i] = 1;
    wait_rsp(6, 300, "t3_rsp_seen");
    check("t3_n_grants", grants.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("t3_grant%0d", i), grants[i], exp3[i]);
    check("t3_n_inits", n_inits - base_inits, 6);

    // 4: read from requester 3 with engine error.
    do_reset();
    pay_write[3] = 0; pay_addr[3] = 32'h0000_0C00; pay_wdata[3] = 32'h0;
    eng_fix_delay = 5; eng_fix_res = 1; fix_err = 1; fix_rdata = 32'hDEAD_BEEF;
    en[3] = 1;
    wait_rsp(1, 50, "t4_rsp_seen");
    check("t4_rsp_idx", last_rsp_idx, 3);
    check("t4_eng_write", init_write, 0);
    check("t4_rsp_error", last_rsp_err, 1);
    check("t4_rsp_rdata", last_rsp_rdata, 32'hDEAD_BEEF);
    check("t4_timeout_flag", timeout_flag, 0);

    // 5: engine never answers -> watchdog; later stray done; then done on the
    //    watchdog's final cycle wins.
    do_reset();
    rand_pay = 1; eng_never = 1; en[0] = 1;
    wait_rsp(1, 60, "t5_rsp_seen");
    check("t5_wait_len", rsp_cycs[0] - (init_cycs[0] + 1), 16);
    check("t5_rsp_error", last_rsp_err, 1);
    check("t5_rsp_rdata", last_rsp_rdata, 0);
    eng_never = 0; stray_at = cyc + 3; base_rsp = rsp_count;
    for (int i = 0; i < 8; i++) tick();
    check("t5_stray_no_rsp", rsp_count - base_rsp, 0);
    check("t5_flag_sticky", timeout_flag, 1);
    eng_fix_delay = 16; eng_fix_res = 1; fix_err = 0; fix_rdata = 32'h600D;
    en[1] = 1;
    wait_rsp(1, 60, "t5_next_rsp_seen");
    check("t5_next_idx", last_rsp_idx, 1);
    check("t5_next_error", last_rsp_err, 0);
    check("t5_next_rdata", last_rsp_rdata, 32'h600D);
    check("t5_next_latency", rsp_cycs[1] - init_cycs[1], 17);
    check("t5_flag_still", timeout_flag, 1);

    // 6: reset in the middle of WAIT.
    do_reset();
    rand_pay = 1; eng_fix_delay = 2; en[2] = 1;
    wait_rsp(1, 50, "t6_pre_rsp_seen");
    eng_never = 1; en[3] = 1;
    for (int i = 0; i < 6; i++) tick();
    check("t6_in_wait", busy, 1);
    base_rsp = rsp_count;
    do_reset();
    check("t6_no_rsp", rsp_count - base_rsp, 0);
    rand_pay = 1; stray_at = cyc + 1;
    for (int i = 0; i < 3; i++) tick();
    eng_fix_delay = 3; en[2] = 1; en[3] = 1;
    wait_rsp(2, 100, "t6_rsp_seen");
    check("t6_first", grants[0], 2);
    check("t6_second", grants[1], 3);

    // Randomised traffic with random gaps, delays, errors and stray dones.
    do_reset();
    rand_pay = 1; rand_gap = 1; gap_max = 6; one_shot = 0; rand_stray = 1;
    for (int i = 0; i < NR; i++) en[i] = 1;
    for (int i = 0; i < 3000; i++) tick();
    check("rand_progress", (n_inits > 50), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ttl_gen_axi_txn_arb.md
Name: ttl_gen_axi_txn_arb

Overview:
Round-robin arbiter and sequencer that shares the single AXI-lite master transaction engine of the TTL generator IP among NUM_REQ requesters. Requesters include the pulse-table loader, the status poller and the host-config bridge. The block latches one request and fires the engine's one-cycle init pulse. It waits for the engine's done/error, or for a watchdog timeout, then returns a one-cycle response to the winning requester. It sits between the requesters and the engine's INIT_AXI_TXN / TXN_DONE / ERROR handshake.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, AXI data width
TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before a forced error response (>=2)

Ports:
ACLK  in  1  single clock; all logic is on the rising edge
ARESET  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request; held until matching req_ready
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i occupies slice i
req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester
rsp_valid  out  NUM_REQ  one-cycle completion pulse to the granted requester
rsp_error  out  1  qualifies rsp_valid; 1 = engine error or timeout
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
eng_init_txn  out  1  one-cycle start pulse to the engine
eng_write  out  1  transaction direction to the engine
eng_addr  out  ADDR_WIDTH  transaction address
eng_wdata  out  DATA_WIDTH  transaction write data
eng_txn_done  in  1  engine completion pulse
eng_error  in  1  engine error, sampled with eng_txn_done
eng_rdata  in  DATA_WIDTH  engine read data, sampled with eng_txn_done
busy  out  1  high whenever state != IDLE
timeout_flag  out  1  sticky; set on any timeout, cleared only by ARESET

Behaviour:
- Reset values: every output 0, state IDLE, timeout counter 0, last_grant = NUM_REQ-1 so requester 0 has first priority.
- ARESET mid-transaction aborts immediately to the reset state. No response is issued. A later stray eng_txn_done is ignored.
- States and transitions:
  - IDLE -> ISSUE when any req_valid is high.
  - ISSUE -> WAIT unconditionally after one cycle.
  - WAIT -> RESP on eng_txn_done or on timeout.
  - RESP -> IDLE unconditionally after one cycle.
- Arbitration (IDLE): the winner g is the first asserted req_valid searching from index last_grant+1 upward, wrapping modulo NUM_REQ. On that edge the block registers g and captures req_write[g], req_addr[g] and req_wdata[g] into the eng_* outputs.
- ISSUE cycle: eng_init_txn=1 and req_ready[g]=1, each for exactly one cycle. eng_write, eng_addr and eng_wdata hold stable from ISSUE through RESP.
- Requester obligations: hold valid and payload until ready, then drop valid on the following cycle. A requester must not reassert valid before its rsp_valid.
- WAIT: the counter starts at 0 on WAIT entry and increments every cycle without eng_txn_done.
  - When eng_txn_done is sampled, capture eng_rdata and eng_error and go to RESP.
  - If count == TIMEOUT_CYCLES-1 with no done, go to RESP with rsp_error=1, rsp_rdata=0, and set timeout_flag.
  - Done and timeout in the same cycle: done wins and the engine's result is returned.
- RESP cycle: rsp_valid[g]=1, rsp_error and rsp_rdata driven, last_grant<=g. rsp_rdata and rsp_error are 0 outside RESP.
- eng_txn_done outside WAIT is ignored with no state change.
- Latency: request seen at edge N; init pulse and ready in cycle N+1; done sampled at edge M; rsp_valid in cycle M+1; IDLE in cycle M+2. A pending request is re-arbitrated in cycle M+2.
- req_write/addr/wdata of non-granted requesters are don't-care. Only one-hot req_ready and rsp_valid are ever asserted.

Test Plan:
1. Requester 0 writes addr 0x40, data 0xA5A5_0001. The engine returns done 3 cycles after init with error=0. Required: req_ready[0] 1 cycle after valid; eng_addr=0x40, eng_write=1; rsp_valid[0] with rsp_error=0.
2. req_valid[1] and req_valid[2] rise in the same cycle after reset. Required: grant 1 first, then 2 immediately after 1's RESP; never both ready together.
3. All 4 requesters assert continuously, each re-requesting after its response. Required: grant order 0,1,2,3,0,1 and exactly one eng_init_txn per grant.
4. Read from requester 3 with the engine returning rdata=0xDEAD_BEEF and error=1. Required: rsp_valid[3], rsp_error=1, rsp_rdata=0xDEAD_BEEF; timeout_flag stays 0.
5. TIMEOUT_CYCLES=16, engine never responds. Required: rsp_valid with rsp_error=1, rsp_rdata=0 exactly 16 cycles after WAIT entry; timeout_flag=1 and sticky. A done arriving later is ignored, and the next request proceeds normally.
6. ARESET asserted mid-WAIT for 2 cycles. Required: all outputs 0 asynchronously, no rsp_valid, busy=0, timeout_flag=0. The next request from requester 2 is granted first (last_grant reset to 3).
